// File: rtl/tns_encoder_seq_if.sv
// Handshake bundle between the word source, the TNS encoder and the bus driver.
// The slave modport is the encoder side; master is the source/sink side.
interface tns_encoder_seq_if #(
   parameter int CW = 31,
   parameter int DW = 23
);
   logic          in_valid;
   logic          in_ready;
   logic [DW-1:0] datain;
   logic          out_valid;
   logic          out_ready;
   logic [CW-1:0] codeout;
   logic          out_err;

   modport master (
      output in_valid, datain, out_ready,
      input  in_ready, out_valid, codeout, out_err
   );

   modport slave (
      input  in_valid, datain, out_ready,
      output in_ready, out_valid, codeout, out_err
   );
endinterface

// File: rtl/tns_encoder_seq.sv
// Iterative Fibonacci-weighted TNS encoder: one 3-bit group per clock, with
// per-group history steering ambiguous A digits toward the last codeword.
module tns_encoder_seq #(
   parameter int NG = 10
) (
   input  logic             clock,
   input  logic             rst_n,
   input  logic             hist_clr,
   tns_encoder_seq_if.slave bus
);
   function automatic logic [63:0] fib_w(input int j);
      logic [63:0] a, b, t;
      a = 64'd1;
      b = 64'd2;
      if (j == 0) return a;
      for (int i = 1; i < j; i++) begin
         t = a + b;
         a = b;
         b = t;
      end
      return b;
   endfunction

   localparam int          CW     = 3 * NG + 1;
   localparam logic [63:0] MAXV   = fib_w(CW + 1) - 64'd2;
   localparam int          DW     = $clog2(MAXV + 64'd1);
   localparam int          CNTW   = $clog2(NG + 1);
   localparam logic [DW-1:0] MAXV_W = DW'(MAXV);
   localparam logic [DW-1:0] W_TOP  = DW'(fib_w(CW - 1));

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t          state_q, state_d;
   logic [CNTW-1:0] cnt_q, cnt_d;
   logic [DW-1:0]   rem_q, rem_d;
   logic [CW-1:0]   code_q, code_d;
   logic            err_q, err_d;
   logic [NG-1:0]   hist_q, hist_d;

   // Per-group weight tables indexed by group number; entry 0 is unused.
   logic [DW-1:0] wa_tab  [NG+1];
   logic [DW-1:0] wb_tab  [NG+1];
   logic [DW-1:0] wc_tab  [NG+1];
   logic [DW-1:0] wac_tab [NG+1];
   logic [NG-1:0] a_bits;

   assign wa_tab[0]  = '0;
   assign wb_tab[0]  = '0;
   assign wc_tab[0]  = '0;
   assign wac_tab[0] = '0;

   for (genvar gi = 1; gi <= NG; gi++) begin : g_wtab
      assign wa_tab[gi]  = DW'(fib_w(3 * gi - 1));
      assign wb_tab[gi]  = DW'(fib_w(3 * gi - 2));
      assign wc_tab[gi]  = DW'(fib_w(3 * gi - 3));
      assign wac_tab[gi] = DW'(fib_w(3 * gi - 1) + fib_w(3 * gi - 3));
   end

   for (genvar gi = 0; gi < NG; gi++) begin : g_abits
      assign a_bits[gi] = code_q[3 * gi + 2];
   end

   logic          top_bit, a_bit, b_bit, c_bit;
   logic [DW-1:0] r1, r2;
   int unsigned   base;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rem_d   = rem_q;
      code_d  = code_q;
      err_d   = err_q;
      hist_d  = hist_q;
      top_bit = (bus.datain >= W_TOP);
      a_bit   = 1'b0;
      b_bit   = 1'b0;
      c_bit   = 1'b0;
      r1      = rem_q;
      r2      = rem_q;
      base    = 0;

      case (state_q)
         IDLE: begin
            if (bus.in_valid) begin
               code_d = '0;
               if (bus.datain > MAXV_W) begin
                  err_d   = 1'b1;
                  state_d = DONE;
               end else begin
                  code_d[CW-1] = top_bit;
                  rem_d        = bus.datain - (top_bit ? W_TOP : '0);
                  cnt_d        = CNTW'(NG);
                  err_d        = 1'b0;
                  state_d      = CALC;
               end
            end
         end
         CALC: begin
            if (cnt_q != '0) begin
               // Inside [wA, wA+wC) both digit choices are valid; reuse history.
               if (rem_q >= wac_tab[cnt_q])
                  a_bit = 1'b1;
               else if (rem_q < wa_tab[cnt_q])
                  a_bit = 1'b0;
               else
                  a_bit = hist_q[cnt_q - 1'b1];
               r1    = rem_q - (a_bit ? wa_tab[cnt_q] : '0);
               b_bit = (r1 >= wb_tab[cnt_q]);
               r2    = r1 - (b_bit ? wb_tab[cnt_q] : '0);
               if (cnt_q == 1) begin
                  c_bit = r2[0];
                  rem_d = '0;
               end else begin
                  c_bit = (r2 >= wc_tab[cnt_q]);
                  rem_d = r2 - (c_bit ? wc_tab[cnt_q] : '0);
               end
               base = 3 * int'(cnt_q) - 3;
               code_d[base +: 3] = {a_bit, b_bit, c_bit};
               cnt_d = cnt_q - 1'b1;
            end
            if (cnt_q <= 1) state_d = DONE;
         end
         DONE: begin
            if (bus.out_ready) begin
               state_d = IDLE;
               if (!err_q) hist_d = a_bits;
            end
         end
         default: state_d = IDLE;
      endcase

      if (hist_clr) hist_d = '0;
   end

   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         rem_q   <= '0;
         code_q  <= '0;
         err_q   <= 1'b0;
         hist_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rem_q   <= rem_d;
         code_q  <= code_d;
         err_q   <= err_d;
         hist_q  <= hist_d;
      end
   end

   assign bus.in_ready  = (state_q == IDLE);
   assign bus.out_valid = (state_q == DONE);
   assign bus.codeout   = code_q;
   assign bus.out_err   = err_q;
endmodule

// File: tb/tb_tns_encoder_seq.sv
// Self-checking bench: directed NG=2 scenarios plus a randomized NG=10 sweep,
// both compared against an arithmetic reference encoder and the weighted-sum invariant.
module tb_tns_encoder_seq;
   logic clock = 1'b0;
   logic rst_n;
   logic hist_clr2, hist_clr10;

   tns_encoder_seq_if #(.CW(7),  .DW(6))  if2 ();
   tns_encoder_seq_if #(.CW(31), .DW(23)) if10 ();

   tns_encoder_seq #(.NG(2)) u2 (
      .clock(clock), .rst_n(rst_n), .hist_clr(hist_clr2), .bus(if2)
   );
   tns_encoder_seq #(.NG(10)) u10 (
      .clock(clock), .rst_n(rst_n), .hist_clr(hist_clr10), .bus(if10)
   );

   always #5 clock = ~clock;

   int checks = 0;
   int errors = 0;
   longint unsigned w [0:40];
   bit [9:0] hist2_m, hist10_m;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
      checks++;
      assert (obs === exp_v) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
      end
   endtask

   // Reference encoder: top digit, then greedy per group with history tie-break.
   function automatic void model(input int ng, input longint unsigned d, input bit [9:0] h,
                                 output logic [63:0] cw, output bit err);
      int n;
      longint unsigned rem;
      bit a, b, c;
      n   = 3 * ng + 1;
      cw  = '0;
      err = 1'b0;
      rem = d;
      if (d > w[n+1] - 2) begin
         err = 1'b1;
         return;
      end
      if (rem >= w[n-1]) begin
         cw[n-1] = 1'b1;
         rem -= w[n-1];
      end
      for (int k = ng; k >= 1; k--) begin
         if (rem < w[3*k-1]) a = 1'b0;
         else if (rem >= w[3*k-1] + w[3*k-3]) a = 1'b1;
         else a = h[k-1];
         if (a) rem -= w[3*k-1];
         b = (rem >= w[3*k-2]);
         if (b) rem -= w[3*k-2];
         c = (rem >= w[3*k-3]);
         if (c) rem -= w[3*k-3];
         cw[3*k-1] = a;
         cw[3*k-2] = b;
         cw[3*k-3] = c;
      end
   endfunction

   function automatic longint unsigned wsum(input int ng, input logic [63:0] cw);
      longint unsigned s = 0;
      for (int j = 0; j < 3 * ng + 1; j++)
         if (cw[j] === 1'b1) s += w[j];
      return s;
   endfunction

   function automatic logic ov(input int ng);
      return (ng == 2) ? if2.out_valid : if10.out_valid;
   endfunction
   function automatic logic ir(input int ng);
      return (ng == 2) ? if2.in_ready : if10.in_ready;
   endfunction
   function automatic logic [63:0] cwo(input int ng);
      return (ng == 2) ? 64'(if2.codeout) : 64'(if10.codeout);
   endfunction
   function automatic logic ero(input int ng);
      return (ng == 2) ? if2.out_err : if10.out_err;
   endfunction

   task automatic drv(input int ng, input longint unsigned d, input logic v);
      if (ng == 2) begin
         if2.datain   = d[5:0];
         if2.in_valid = v;
      end else begin
         if10.datain   = d[22:0];
         if10.in_valid = v;
      end
   endtask

   // One full word: present, wait for out_valid, check, then handshake.
   task automatic xact(input int ng, input longint unsigned d, input bit hclr,
                       input bit has_want, input logic [63:0] want);
      logic [63:0] cw_exp, cw_obs;
      bit err_exp;
      logic err_obs;
      int lat, lat_exp;
      bit [9:0] h;
      h = (ng == 2) ? hist2_m : hist10_m;
      model(ng, d, h, cw_exp, err_exp);
      drv(ng, d, 1'b1);
      @(posedge clock); #1;
      drv(ng, d, 1'b0);
      lat = 0;
      while (ov(ng) !== 1'b1 && lat < 50) begin
         @(posedge clock); #1;
         lat++;
      end
      cw_obs  = cwo(ng);
      err_obs = ero(ng);
      // Error words skip CALC and reach DONE on the accepting edge.
      lat_exp = err_exp ? 0 : ng;
      check("latency", 64'(lat), 64'(lat_exp));
      check("codeout", cw_obs, cw_exp);
      check("out_err", 64'(err_obs), 64'(err_exp));
      if (has_want) check("codeout_directed", cw_obs, want);
      if (!err_exp) check("weighted_sum", 64'(wsum(ng, cw_obs)), 64'(d));
      $display("xact ng=%0d datain=%0d codeout=%0h out_err=%0b latency=%0d hist_clr=%0b",
               ng, d, cw_obs, err_obs, lat, hclr);
      if (ng == 2) begin
         if2.out_ready = 1'b1;
         hist_clr2     = hclr;
      end else begin
         if10.out_ready = 1'b1;
         hist_clr10     = hclr;
      end
      @(posedge clock); #1;
      if2.out_ready  = 1'b0;
      if10.out_ready = 1'b0;
      hist_clr2      = 1'b0;
      hist_clr10     = 1'b0;
      if (hclr) h = '0;
      else if (!err_exp) for (int k = 1; k <= ng; k++) h[k-1] = cw_exp[3*k-1];
      if (ng == 2) hist2_m = h;
      else hist10_m = h;
      check("idle_in_ready", 64'(ir(ng)), 64'd1);
      check("idle_out_valid", 64'(ov(ng)), 64'd0);
   endtask

   initial begin
      longint unsigned d;
      w[0] = 1;
      w[1] = 2;
      for (int j = 2; j <= 40; j++) w[j] = w[j-1] + w[j-2];

      rst_n = 1'b0;
      hist_clr2 = 1'b0;
      hist_clr10 = 1'b0;
      if2.in_valid = 1'b0;  if2.datain = '0;  if2.out_ready = 1'b0;
      if10.in_valid = 1'b0; if10.datain = '0; if10.out_ready = 1'b0;
      hist2_m = '0;
      hist10_m = '0;
      repeat (2) @(posedge clock);
      #1;
      check("rst_in_ready",  64'(if2.in_ready),  64'd1);
      check("rst_out_valid", 64'(if2.out_valid), 64'd0);
      check("rst_out_err",   64'(if2.out_err),   64'd0);
      check("rst_codeout",   64'(if2.codeout),   64'd0);
      check("rst10_in_ready", 64'(if10.in_ready), 64'd1);
      check("rst10_codeout",  64'(if10.codeout),  64'd0);
      rst_n = 1'b1;
      @(posedge clock); #1;

      xact(2, 0,  1'b0, 1'b1, 64'h00);
      xact(2, 14, 1'b0, 1'b1, 64'h19);
      xact(2, 53, 1'b0, 1'b1, 64'h7F);
      xact(2, 14, 1'b0, 1'b1, 64'h21);
      xact(2, 54, 1'b0, 1'b1, 64'h00);
      xact(2, 14, 1'b0, 1'b1, 64'h21);
      hist_clr2 = 1'b1;
      @(posedge clock); #1;
      hist_clr2 = 1'b0;
      hist2_m = '0;
      xact(2, 54, 1'b0, 1'b1, 64'h00);
      xact(2, 14, 1'b0, 1'b1, 64'h19);

      // Backpressure: hold the 53 codeword while stray in_valid pulses arrive.
      drv(2, 53, 1'b1);
      @(posedge clock); #1;
      drv(2, 0, 1'b0);
      repeat (2) @(posedge clock);
      #1;
      check("bp_out_valid", 64'(if2.out_valid), 64'd1);
      for (int i = 0; i < 5; i++) begin
         if2.in_valid = i[0];
         if2.datain   = 6'(i * 7 + 1);
         @(posedge clock); #1;
         check("bp_codeout",  64'(if2.codeout),   64'h7F);
         check("bp_in_ready", 64'(if2.in_ready),  64'd0);
         check("bp_valid",    64'(if2.out_valid), 64'd1);
      end
      if2.in_valid  = 1'b0;
      if2.out_ready = 1'b1;
      @(posedge clock); #1;
      if2.out_ready = 1'b0;
      hist2_m = 10'b11;
      $display("xact ng=2 datain=53 codeout=7f backpressure release");
      check("bp_idle_in_ready",  64'(if2.in_ready),  64'd1);
      check("bp_idle_out_valid", 64'(if2.out_valid), 64'd0);
      xact(2, 14, 1'b0, 1'b1, 64'h21);

      xact(2, 53, 1'b1, 1'b1, 64'h7F);
      xact(2, 14, 1'b0, 1'b1, 64'h19);

      // Asynchronous reset in the middle of CALC.
      drv(2, 53, 1'b1);
      @(posedge clock); #1;
      drv(2, 0, 1'b0);
      check("calc_in_ready", 64'(if2.in_ready), 64'd0);
      rst_n = 1'b0;
      #1;
      check("arst_in_ready",  64'(if2.in_ready),  64'd1);
      check("arst_out_valid", 64'(if2.out_valid), 64'd0);
      check("arst_out_err",   64'(if2.out_err),   64'd0);
      check("arst_codeout",   64'(if2.codeout),   64'd0);
      @(posedge clock); #1;
      rst_n = 1'b1;
      hist2_m = '0;
      hist10_m = '0;
      $display("xact ng=2 reset during CALC");
      xact(2, 14, 1'b0, 1'b1, 64'h19);

      for (int i = 0; i < 40; i++) begin
         d = 64'($urandom_range(63, 0));
         xact(2, d, ($urandom_range(7, 0) == 0), 1'b0, 64'd0);
      end

      xact(10, 0,       1'b0, 1'b1, 64'd0);
      xact(10, 5702885, 1'b0, 1'b1, 64'h7FFF_FFFF);
      xact(10, 5702886, 1'b0, 1'b1, 64'd0);
      for (int i = 0; i < 2000; i++) begin
         if ($urandom_range(49, 0) == 0) d = 64'($urandom_range(8388607, 5702886));
         else d = 64'($urandom_range(5702885, 0));
         xact(10, d, ($urandom_range(15, 0) == 0), 1'b0, 64'd0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
